// File: rtl/alu_sequencer_if.sv
// Bundles the two requester command ports, the shared-ALU drive/return
// signals and the tagged result port of alu_sequencer.
interface alu_sequencer_if #(
    parameter int W = 24
);
    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic [W-1:0] alu_R;
    logic [W-1:0] alu_S;
    logic         alu_ctl_f;
    logic         alu_ctl_e;
    logic         alu_inv_rst;
    logic [W-1:0] alu_result;
    logic         alu_cont;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_id;
    logic         out_err;

    // Sequencer side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_R, alu_S, alu_ctl_f, alu_ctl_e, alu_inv_rst,
        input  alu_result, alu_cont,
        output out_valid, out_data, out_id, out_err,
        input  out_ready
    );

    // Requesters, ALU and result consumer side.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_R, alu_S, alu_ctl_f, alu_ctl_e, alu_inv_rst,
        output alu_result, alu_cont,
        input  out_valid, out_data, out_id, out_err,
        output out_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Shares one S9.14 sign-magnitude ALU between two requesters: round-robin
// grant, operand registration, SUB via sign flip of S, sequencing of the
// multi-cycle inverse with timeout, and a tagged valid/ready result.
module alu_sequencer #(
    parameter int W           = 24,
    parameter int INV_TIMEOUT = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam int WC_W = $clog2(INV_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        INV_RST,
        INV_WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_INV = 2'b11
    } op_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    op_t              op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             id_q, id_d;
    logic [W-1:0]     data_q, data_d;
    logic             err_q, err_d;
    logic             inv_rst_q;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    logic             gnt0, gnt1;
    op_t              sel_op;
    logic [W-1:0]     sel_a, sel_b;

    // Round-robin grant: last_q names the requester served most recently.
    always_comb begin
        gnt1   = bus.req1_valid && (!bus.req0_valid || !last_q);
        gnt0   = bus.req0_valid && !gnt1;
        sel_op = gnt1 ? op_t'(bus.req1_op) : op_t'(bus.req0_op);
        sel_a  = gnt1 ? bus.req1_a : bus.req0_a;
        sel_b  = gnt1 ? bus.req1_b : bus.req0_b;
        bus.req0_ready = (state_q == IDLE) && gnt0;
        bus.req1_ready = (state_q == IDLE) && gnt1;
    end

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d   = gnt1;
                    last_d = gnt1;
                    op_d   = sel_op;
                    a_d    = sel_a;
                    // The ALU has no subtract; negate S by flipping its sign bit.
                    b_d    = (sel_op == OP_SUB) ? {~sel_b[W-1], sel_b[W-2:0]} : sel_b;
                    if (sel_op == OP_INV) begin
                        if (sel_a[W-2:0] == '0) begin
                            data_d  = {1'b0, {(W-1){1'b1}}};
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = INV_RST;
                        end
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                data_d  = bus.alu_result;
                err_d   = 1'b0;
                state_d = DONE;
            end
            INV_RST: begin
                wcnt_d  = '0;
                state_d = INV_WAIT;
            end
            INV_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (bus.alu_cont) begin
                    data_d  = bus.alu_result;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wcnt_d == WC_W'(INV_TIMEOUT)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ops_d   = ops_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU operand and control drive, decoded from the current state.
    always_comb begin
        bus.alu_R     = '0;
        bus.alu_S     = '0;
        bus.alu_ctl_f = 1'b0;
        bus.alu_ctl_e = 1'b0;
        case (state_q)
            ISSUE: begin
                bus.alu_R     = a_q;
                bus.alu_S     = b_q;
                bus.alu_ctl_f = (op_q == OP_MUL);
            end
            INV_RST, INV_WAIT: begin
                bus.alu_R     = a_q;
                bus.alu_S     = b_q;
                bus.alu_ctl_f = 1'b1;
                bus.alu_ctl_e = 1'b1;
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
            ops_q     <= '0;
            inv_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            data_q    <= data_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
            ops_q     <= ops_d;
            inv_rst_q <= (state_d == INV_RST);
        end
    end

    // Result port and status outputs.
    always_comb begin
        bus.out_valid   = (state_q == DONE);
        bus.out_data    = data_q;
        bus.out_id      = id_q;
        bus.out_err     = err_q;
        bus.alu_inv_rst = inv_rst_q;
        busy            = (state_q != IDLE);
        ops_done        = ops_q;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural sign-magnitude ALU.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [15:0] ops_done;
    logic        inv_en = 1'b0;
    int          inv_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.W(24)) bus ();

    alu_sequencer #(.W(24), .INV_TIMEOUT(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .ops_done (ops_done)
    );

    function automatic int sm2i(input logic [23:0] x);
        int m;
        m = int'(x[22:0]);
        return x[23] ? -m : m;
    endfunction

    function automatic logic [23:0] i2sm(input int v);
        logic [22:0] m;
        if (v < 0) begin
            m = 23'(-v);
            return {1'b1, m};
        end
        m = 23'(v);
        return {1'b0, m};
    endfunction

    // Inverse model: cont rises on the 24th cycle after its reset pulse.
    always @(posedge clk) begin
        if (bus.alu_inv_rst) inv_cnt <= 0;
        else if (bus.alu_ctl_e) inv_cnt <= inv_cnt + 1;
    end

    // Combinational ALU model: add, multiply, reciprocal.
    always_comb begin
        longint p;
        int     r;
        p = 0;
        r = sm2i(bus.alu_R);
        bus.alu_cont = inv_en && bus.alu_ctl_e && (inv_cnt >= 23);
        if (!bus.alu_ctl_f) begin
            bus.alu_result = i2sm(r + sm2i(bus.alu_S));
        end else if (!bus.alu_ctl_e) begin
            p = longint'(r) * longint'(sm2i(bus.alu_S));
            bus.alu_result = i2sm(int'(p >>> 14));
        end else begin
            bus.alu_result = (r == 0) ? 24'h0 : i2sm((1 << 28) / r);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    // Presents one command and returns one cycle after the accepting edge.
    task automatic send(input bit id, input logic [1:0] op, input logic [23:0] a,
                        input logic [23:0] b, output bit ok);
        ok = 1'b0;
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) ok = 1'b1;
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.alu_inv_rst !== 1'b1) begin failures++; $display("FAIL reset_inv_rst got %b want 1", bus.alu_inv_rst); end
        checks++; if (ops_done !== 16'd0) begin failures++; $display("FAIL reset_ops got %0d want 0", ops_done); end
        checks++; if (bus.alu_R !== 24'h0) begin failures++; $display("FAIL reset_alu_R got %h want 000000", bus.alu_R); end
        rst = 1'b1;
        cyc();
        checks++; if (bus.alu_inv_rst !== 1'b0) begin failures++; $display("FAIL post_reset_inv_rst got %b want 0", bus.alu_inv_rst); end
    endtask

    task automatic test_add();
        bit ok;
        send(1'b0, 2'b00, 24'h004000, 24'h008000, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL add_grant got %b want 1", ok); end
        checks++; if (bus.alu_R !== 24'h004000 || bus.alu_S !== 24'h008000) begin failures++; $display("FAIL add_operands got %h/%h want 004000/008000", bus.alu_R, bus.alu_S); end
        checks++; if ({bus.alu_ctl_f, bus.alu_ctl_e} !== 2'b00) begin failures++; $display("FAIL add_ctl got %b want 00", {bus.alu_ctl_f, bus.alu_ctl_e}); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got %b want 0", bus.out_valid); end
        cyc();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_latency got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 24'h00C000) begin failures++; $display("FAIL add_data got %h want 00c000", bus.out_data); end
        checks++; if ({bus.out_id, bus.out_err} !== 2'b00) begin failures++; $display("FAIL add_id_err got %b want 00", {bus.out_id, bus.out_err}); end
        release_out();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_release got %b want 0", bus.out_valid); end
        checks++; if (ops_done !== 16'd1) begin failures++; $display("FAIL add_ops got %0d want 1", ops_done); end
    endtask

    task automatic test_sub();
        bit ok;
        send(1'b1, 2'b01, 24'h004000, 24'h00C000, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sub_grant got %b want 1", ok); end
        checks++; if (bus.alu_S !== 24'h80C000 || bus.alu_R !== 24'h004000) begin failures++; $display("FAIL sub_operands got %h/%h want 004000/80c000", bus.alu_R, bus.alu_S); end
        bus.req0_valid = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL busy_ack got %b want 0", bus.req0_ready); end
        bus.req0_valid = 1'b0;
        cyc();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h808000) begin failures++; $display("FAIL sub_data got %b/%h want 1/808000", bus.out_valid, bus.out_data); end
        checks++; if (bus.out_id !== 1'b1) begin failures++; $display("FAIL sub_id got %b want 1", bus.out_id); end
        release_out();
    endtask

    task automatic test_mul();
        bit ok;
        send(1'b0, 2'b10, 24'h808000, 24'h006000, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mul_grant got %b want 1", ok); end
        checks++; if ({bus.alu_ctl_f, bus.alu_ctl_e} !== 2'b10) begin failures++; $display("FAIL mul_ctl got %b want 10", {bus.alu_ctl_f, bus.alu_ctl_e}); end
        cyc();
        checks++; if (bus.out_data !== 24'h80C000 || bus.out_err !== 1'b0) begin failures++; $display("FAIL mul_data got %h/%b want 80c000/0", bus.out_data, bus.out_err); end
        release_out();
        checks++; if (ops_done !== 16'd3) begin failures++; $display("FAIL mul_ops got %0d want 3", ops_done); end
    endtask

    task automatic test_back_to_back();
        logic        gid [4];
        logic        oid [4];
        logic [23:0] odat[4];
        int          ng = 0;
        int          no = 0;
        do_reset();
        bus.out_ready = 1'b1;
        bus.req0_op = 2'b00; bus.req0_a = 24'h004000; bus.req0_b = 24'h004000;
        bus.req1_op = 2'b00; bus.req1_a = 24'h008000; bus.req1_b = 24'h004000;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (bus.out_valid === 1'b1 && no < 4) begin
                oid[no] = bus.out_id; odat[no] = bus.out_data; no++;
            end
            if (no == 4) break;
            if (ng >= 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
            #1;
            if (ng < 4 && bus.req0_ready === 1'b1) begin gid[ng] = 1'b0; ng++; end
            else if (ng < 4 && bus.req1_ready === 1'b1) begin gid[ng] = 1'b1; ng++; end
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++; if (no != 4) begin failures++; $display("FAIL b2b_count got %0d want 4", no); end
        if (no == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (gid[k] !== k[0]) begin failures++; $display("FAIL b2b_grant%0d got %b want %b", k, gid[k], k[0]); end
                checks++; if (oid[k] !== k[0]) begin failures++; $display("FAIL b2b_id%0d got %b want %b", k, oid[k], k[0]); end
                checks++; if (odat[k] !== (k[0] ? 24'h00C000 : 24'h008000)) begin failures++; $display("FAIL b2b_data%0d got %h want %h", k, odat[k], k[0] ? 24'h00C000 : 24'h008000); end
            end
        end
        cyc();
        bus.out_ready = 1'b0;
        checks++; if (ops_done !== 16'd4) begin failures++; $display("FAIL b2b_ops got %0d want 4", ops_done); end
    endtask

    task automatic test_inv_timeout();
        bit ok;
        bit seen = 1'b0;
        int e = 0;
        int r = 0;
        inv_en = 1'b0;
        send(1'b0, 2'b11, 24'h008000, 24'h000000, ok);
        for (int c = 0; c < 80; c++) begin
            if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
            if (bus.alu_ctl_e === 1'b1) e++;
            if (bus.alu_inv_rst === 1'b1) r++;
            cyc();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL inv_to_done got %b want 1", seen); end
        checks++; if (e != 33) begin failures++; $display("FAIL inv_to_cycles got %0d want 33", e); end
        checks++; if (r != 1) begin failures++; $display("FAIL inv_to_rst_pulse got %0d want 1", r); end
        checks++; if (bus.out_err !== 1'b1 || bus.out_data !== 24'h0) begin failures++; $display("FAIL inv_to_result got %b/%h want 1/000000", bus.out_err, bus.out_data); end
        release_out();
    endtask

    task automatic test_inv_zero();
        bit ok;
        send(1'b1, 2'b11, 24'h800000, 24'h123456, ok);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1) begin failures++; $display("FAIL invz_valid_err got %b/%b want 1/1", bus.out_valid, bus.out_err); end
        checks++; if (bus.out_data !== 24'h7FFFFF || bus.out_id !== 1'b1) begin failures++; $display("FAIL invz_data got %h/%b want 7fffff/1", bus.out_data, bus.out_id); end
        checks++; if (bus.alu_inv_rst !== 1'b0 || bus.alu_ctl_e !== 1'b0) begin failures++; $display("FAIL invz_no_start got %b/%b want 0/0", bus.alu_inv_rst, bus.alu_ctl_e); end
        cyc();
        checks++; if (bus.alu_inv_rst !== 1'b0) begin failures++; $display("FAIL invz_no_pulse got %b want 0", bus.alu_inv_rst); end
        release_out();
    endtask

    task automatic test_inv_nominal();
        bit ok;
        bit seen = 1'b0;
        int e = 0;
        inv_en = 1'b1;
        send(1'b0, 2'b11, 24'h008000, 24'h000000, ok);
        for (int c = 0; c < 80; c++) begin
            if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
            if (bus.alu_ctl_e === 1'b1) e++;
            cyc();
        end
        inv_en = 1'b0;
        checks++; if (seen !== 1'b1 || e != 25) begin failures++; $display("FAIL inv_latency got %b/%0d want 1/25", seen, e); end
        checks++; if (bus.out_data !== 24'h002000 || bus.out_err !== 1'b0) begin failures++; $display("FAIL inv_result got %h/%b want 002000/0", bus.out_data, bus.out_err); end
        release_out();
    endtask

    task automatic test_rst_midflight();
        bit ok;
        bus.out_ready = 1'b0;
        send(1'b1, 2'b11, 24'h008000, 24'h000000, ok);
        cyc(); cyc(); cyc();
        checks++; if (busy !== 1'b1 || bus.alu_ctl_e !== 1'b1) begin failures++; $display("FAIL mid_inflight got %b/%b want 1/1", busy, bus.alu_ctl_e); end
        rst = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_idle got %b/%b want 0/0", busy, bus.out_valid); end
        checks++; if (bus.alu_inv_rst !== 1'b1) begin failures++; $display("FAIL mid_inv_rst got %b want 1", bus.alu_inv_rst); end
        rst = 1'b1;
        cyc(); cyc();
        checks++; if (ops_done !== 16'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got %0d/%b want 0/0", ops_done, bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        send(1'b0, 2'b00, 24'h004000, 24'h004000, ok);
        cyc();
        for (int c = 0; c < 10; c++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h008000 || bus.out_id !== 1'b0) begin failures++; $display("FAIL hold%0d got %b/%h/%b want 1/008000/0", c, bus.out_valid, bus.out_data, bus.out_id); end
            cyc();
        end
        release_out();
        checks++; if (ops_done !== 16'd1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got %0d/%b want 1/0", ops_done, bus.out_valid); end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_inv_timeout();
        test_inv_zero();
        test_inv_nominal();
        test_rst_midflight();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that shares one alu instance between two requesters (e.g. Kalman predict and update engines).
- Arbitrates round-robin, registers operands, and drives R/S/ctl_f/ctl_e.
- Synthesises SUB, which the ALU control encoding cannot select, by flipping the sign of S.
- Sequences the 24-cycle inverse: issues its reset pulse, waits on cont, applies a timeout, and returns a tagged result over a valid/ready port.

Parameters:
- W, 24, operand width in S9.14 sign-magnitude format. Fixed at 24; other values are unsupported.
- INV_TIMEOUT, 32, maximum INV_WAIT cycles before an inverse is aborted with an error.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted.
- req0_op  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 INV.
- req0_a  in  24  operand A, driven to R.
- req0_b  in  24  operand B, driven to S (ignored for INV).
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- alu_R  out  24  ALU R operand.
- alu_S  out  24  ALU S operand.
- alu_ctl_f  out  1  ALU ctl_f.
- alu_ctl_e  out  1  ALU ctl_e.
- alu_inv_rst  out  1  active-high reset to the ALU inverse unit.
- alu_result  in  24  ALU result.
- alu_cont  in  1  ALU continue/ready.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_data  out  24  result, S9.14.
- out_id  out  1  requester that issued the command.
- out_err  out  1  inverse timeout or inverse of zero.
- busy  out  1  high whenever state is not IDLE.
- ops_done  out  CNT_W  count of completed results; wraps.

Behaviour:
- Reset values (rst=0 at a clock edge):
  - state=IDLE.
  - All registered outputs 0, except alu_inv_rst=1.
  - Round-robin pointer set so req0 has priority.
  - ops_done=0.
- States: IDLE, ISSUE, INV_RST, INV_WAIT, DONE.
- IDLE:
  - Grant: with one valid requester, grant it; with both valid, grant the requester not granted last.
  - reqN_ready is high combinationally in IDLE for the granted requester only.
  - On the handshake, latch op, a, b and id, then update the pointer.
  - A SUB latches b with bit 23 inverted.
  - A MUL latches the unchanged a and b.
  - Next state: ADD/SUB/MUL -> ISSUE.
  - INV with a[22:0]==0 -> DONE with out_err=1 and out_data=24'h7FFFFF; the ALU is not started.
  - Other INV -> INV_RST.
- ALU drive:
  - alu_R and alu_S hold the latched operands from ISSUE through INV_WAIT.
  - ISSUE: ADD/SUB drive ctl_f=0, ctl_e=0; MUL drives ctl_f=1, ctl_e=0.
  - INV_RST and INV_WAIT: ctl_f=1, ctl_e=1.
  - IDLE and DONE: ctl_f=0, ctl_e=0, alu_R=alu_S=0.
  - alu_inv_rst is registered: 1 for exactly the INV_RST cycle, 0 otherwise after reset release.
- ISSUE: capture alu_result into out_data at the end of the cycle, set out_err=0, go to DONE.
  - Latency for ADD/SUB/MUL: handshake in cycle T, out_valid first high in T+2.
- INV_RST: lasts one cycle; alu_cont is ignored; clear the wait counter; go to INV_WAIT.
- INV_WAIT: increment the wait counter each cycle.
  - On the first cycle with alu_cont=1: capture alu_result, set out_err=0, go to DONE.
  - If the counter reaches INV_TIMEOUT with alu_cont=0: set out_data=0, out_err=1, go to DONE.
  - A nominal inverse returns out_valid about 25 cycles after the handshake.
- DONE:
  - out_valid=1; out_data, out_id and out_err are stable until out_ready=1.
  - On out_ready=1, increment ops_done (wrapping at 2^CNT_W) and go to IDLE.
  - No new grant occurs in the DONE cycle, so at most one command is in flight.
- Simultaneous events:
  - A requester may drop valid without being granted; this has no effect.
  - req_valid during a busy state is not acknowledged.
- rst low in any state: next state is IDLE, any in-flight command is discarded with no output, and alu_inv_rst returns to 1.

Test Plan:
- req0 ADD a=24'h004000 (1.0), b=24'h008000 (2.0) -> out_data=24'h00C000, out_id=0, out_err=0, out_valid 2 cycles after handshake.
- req1 SUB a=24'h004000, b=24'h00C000 -> out_data=24'h808000 (-2.0); alu_S observed as 24'h80C000 in ISSUE.
- MUL a=24'h808000 (-2.0), b=24'h006000 (1.5) -> out_data=24'h80C000; ctl_f=1, ctl_e=0 in ISSUE.
- Both requesters valid for 4 back-to-back ADDs, out_ready tied high -> grants alternate 0,1,0,1; ops_done=4.
- INV with ALU model holding alu_cont=0 -> out_err=1, out_data=0 after INV_TIMEOUT wait cycles; INV of a=24'h800000 -> immediate err with out_data=24'h7FFFFF, alu_inv_rst never pulsed.
- Assert rst=0 in INV_WAIT with out_ready held low -> next cycle IDLE, out_valid=0, alu_inv_rst=1, no ops_done increment; DONE backpressure holds out_data stable for 10 cycles.
